mw_pipe_stage: RTL and testbench



---
 rtl/core_pkg.sv | 36 +++
 rtl/mw_pipe_stage_if.sv | 33 +++
 rtl/skid_buf2.sv | 108 ++++++++++
 rtl/mw_pipe_stage.sv | 83 ++++++++
 tb/tb_mw_pipe_stage.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared types and default widths for the pipelined RISC-V core.
package core_pkg;

   localparam int unsigned DEF_XLEN       = 32;
   localparam int unsigned DEF_REG_ADDR_W = 5;
   localparam int unsigned DEF_RES_SEL_W  = 2;

   typedef enum logic [1:0] {
      RES_ALU = 2'd0,
      RES_MEM = 2'd1,
      RES_PC4 = 2'd2,
      RES_IMM = 2'd3
   } res_src_e;

   typedef struct packed {
      logic [DEF_XLEN-1:0]       result;
      logic [DEF_REG_ADDR_W-1:0] rd;
      logic                      reg_write;
   } wb_entry_t;

   // Entry count of the 2-deep skid buffer.
   typedef enum logic [1:0] {
      SB_EMPTY = 2'd0,
      SB_FULL  = 2'd1,
      SB_SKID  = 2'd2
   } skid_state_e;

   // Head register update chosen by the skid buffer FSM.
   typedef enum logic [1:0] {
      HOP_HOLD  = 2'd0,
      HOP_IN    = 2'd1,
      HOP_SKID  = 2'd2,
      HOP_CLEAR = 2'd3
   } head_op_e;

endpackage

// File: rtl/mw_pipe_stage_if.sv
// MEM->WB handshake and payload bundle; master is the environment, slave is the stage.
interface mw_pipe_stage_if #(
   parameter int unsigned XLEN       = core_pkg::DEF_XLEN,
   parameter int unsigned REG_ADDR_W = core_pkg::DEF_REG_ADDR_W,
   parameter int unsigned RES_SEL_W  = core_pkg::DEF_RES_SEL_W
);
   logic                  m_valid;
   logic                  m_ready;
   logic [XLEN-1:0]       alu_result_m;
   logic [XLEN-1:0]       read_data_m;
   logic [XLEN-1:0]       imm_ext_m;
   logic [XLEN-1:0]       pc_plus4_m;
   logic [REG_ADDR_W-1:0] rd_m;
   logic                  reg_write_m;
   logic [RES_SEL_W-1:0]  result_src_m;
   logic                  w_valid;
   logic                  w_ready;
   logic [XLEN-1:0]       result_w;
   logic [REG_ADDR_W-1:0] rd_w;
   logic                  reg_write_w;

   modport master (
      output m_valid, alu_result_m, read_data_m, imm_ext_m, pc_plus4_m,
             rd_m, reg_write_m, result_src_m, w_ready,
      input  m_ready, w_valid, result_w, rd_w, reg_write_w
   );

   modport slave (
      input  m_valid, alu_result_m, read_data_m, imm_ext_m, pc_plus4_m,
             rd_m, reg_write_m, result_src_m, w_ready,
      output m_ready, w_valid, result_w, rd_w, reg_write_w
   );
endinterface

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready buffer on an opaque payload with flush.
// Invalid entries are held at zero so payload outputs are quiet when empty.
module skid_buf2
   import core_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   skid_state_e  state_q, state_d;
   head_op_e     head_op;
   logic         skid_load, skid_clear;
   logic         valid_q, ready_q;
   logic         accept, retire;
   logic [W-1:0] head_q, skid_q;

   assign accept    = in_valid & ready_q;
   assign retire    = valid_q & out_ready;
   assign in_ready  = ready_q;
   assign out_valid = valid_q;
   assign out_data  = head_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SB_EMPTY;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         valid_q <= (state_d != SB_EMPTY);
         ready_q <= (state_d != SB_SKID);
      end
   end

   // Flush overrides everything; skid never bypasses the head.
   always_comb begin
      state_d    = state_q;
      head_op    = HOP_HOLD;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
         state_d    = SB_EMPTY;
         head_op    = HOP_CLEAR;
         skid_clear = 1'b1;
      end else begin
         case (state_q)
            SB_EMPTY: begin
               if (accept) begin
                  state_d = SB_FULL;
                  head_op = HOP_IN;
               end
            end
            SB_FULL: begin
               if (accept && retire) begin
                  head_op = HOP_IN;
               end else if (accept) begin
                  state_d   = SB_SKID;
                  skid_load = 1'b1;
               end else if (retire) begin
                  state_d = SB_EMPTY;
                  head_op = HOP_CLEAR;
               end
            end
            SB_SKID: begin
               if (retire) begin
                  state_d    = SB_FULL;
                  head_op    = HOP_SKID;
                  skid_clear = 1'b1;
               end
            end
            default: begin
               state_d    = SB_EMPTY;
               head_op    = HOP_CLEAR;
               skid_clear = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q <= '0;
         skid_q <= '0;
      end else begin
         case (head_op)
            HOP_IN:    head_q <= in_data;
            HOP_SKID:  head_q <= skid_q;
            HOP_CLEAR: head_q <= '0;
            default:   head_q <= head_q;
         endcase
         if (skid_clear) begin
            skid_q <= '0;
         end else if (skid_load) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/mw_pipe_stage.sv
// MEM->WB pipeline stage: capture-time result mux, 2-entry skid buffer, x0 write suppression.
// Define MW_PIPE_PERF_EN to add saturating retired/stall/flush counters.
module mw_pipe_stage
   import core_pkg::*;
#(
   parameter int unsigned XLEN       = DEF_XLEN,
   parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int unsigned RES_SEL_W  = DEF_RES_SEL_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_w,
   mw_pipe_stage_if.slave        io
`ifdef MW_PIPE_PERF_EN
   ,
   output logic [31:0]           perf_retired,
   output logic [31:0]           perf_stall,
   output logic [31:0]           perf_flush
`endif
);

   localparam int unsigned EW = XLEN + REG_ADDR_W + 1;

   typedef struct packed {
      logic [XLEN-1:0]       result;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
   } entry_t;

   entry_t in_e, head_e;

   // Only the selected result is stored; the write enable is pre-qualified against x0.
   always_comb begin
      in_e = '0;
      case (io.result_src_m)
         RES_SEL_W'(RES_ALU): in_e.result = io.alu_result_m;
         RES_SEL_W'(RES_MEM): in_e.result = io.read_data_m;
         RES_SEL_W'(RES_PC4): in_e.result = io.pc_plus4_m;
         RES_SEL_W'(RES_IMM): in_e.result = io.imm_ext_m;
         default:             in_e.result = '0;
      endcase
      in_e.rd        = io.rd_m;
      in_e.reg_write = io.reg_write_m & (io.rd_m != '0);
   end

   skid_buf2 #(.W(EW)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush_w),
      .in_valid  (io.m_valid),
      .in_ready  (io.m_ready),
      .in_data   (in_e),
      .out_valid (io.w_valid),
      .out_ready (io.w_ready),
      .out_data  (head_e)
   );

   // Head is zeroed whenever invalid, so its write bit is already valid-qualified.
   assign io.result_w    = head_e.result;
   assign io.rd_w        = head_e.rd;
   assign io.reg_write_w = head_e.reg_write;

`ifdef MW_PIPE_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_retired <= '0;
         perf_stall   <= '0;
         perf_flush   <= '0;
      end else begin
         if (io.w_valid && io.w_ready && (perf_retired != '1)) begin
            perf_retired <= perf_retired + 32'd1;
         end
         if (io.w_valid && !io.w_ready && (perf_stall != '1)) begin
            perf_stall <= perf_stall + 32'd1;
         end
         if (flush_w && io.w_valid && (perf_flush != '1)) begin
            perf_flush <= perf_flush + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mw_pipe_stage.sv
// Directed bench for mw_pipe_stage: inputs driven and outputs checked on the falling edge.
module tb_mw_pipe_stage;

   logic clk;
   logic rst_n;
   logic flush_w;
   int   checks;
   int   errors;

   mw_pipe_stage_if #(.XLEN(32), .REG_ADDR_W(5), .RES_SEL_W(2)) io ();

`ifdef MW_PIPE_PERF_EN
   logic [31:0] perf_retired, perf_stall, perf_flush;
`endif

   mw_pipe_stage #(.XLEN(32), .REG_ADDR_W(5), .RES_SEL_W(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_w (flush_w),
      .io      (io)
`ifdef MW_PIPE_PERF_EN
      ,
      .perf_retired (perf_retired),
      .perf_stall   (perf_stall),
      .perf_flush   (perf_flush)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic [31:0] res,
                            input logic [4:0] rd, input logic rw, input logic rdy);
      check({tag, ".w_valid"},     32'(io.w_valid),     32'(v));
      check({tag, ".result_w"},    io.result_w,         res);
      check({tag, ".rd_w"},        32'(io.rd_w),        32'(rd));
      check({tag, ".reg_write_w"}, 32'(io.reg_write_w), 32'(rw));
      check({tag, ".m_ready"},     32'(io.m_ready),     32'(rdy));
   endtask

   task automatic offer(input logic v, input logic [1:0] src, input logic [31:0] alu,
                        input logic [4:0] rd, input logic rw);
      io.m_valid      = v;
      io.result_src_m = src;
      io.alu_result_m = alu;
      io.rd_m         = rd;
      io.reg_write_m  = rw;
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      rst_n           = 1'b0;
      flush_w         = 1'b0;
      io.w_ready      = 1'b0;
      io.read_data_m  = 32'hDEAD_BEEF;
      io.pc_plus4_m   = 32'h0000_0104;
      io.imm_ext_m    = 32'hFFFF_F800;
      offer(1'b0, 2'd0, 32'h0, 5'd0, 1'b0);

      // Reset state
      repeat (2) @(negedge clk);
      check_out("reset", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
`ifdef MW_PIPE_PERF_EN
      check("reset.perf_flush", perf_flush, 32'd0);
`endif

      // Single instruction
      rst_n      = 1'b1;
      io.w_ready = 1'b1;
      offer(1'b1, 2'b00, 32'h0000_1234, 5'd5, 1'b1);
      @(negedge clk);
      check_out("single", 1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b1);

      // Mux coverage back-to-back
      offer(1'b1, 2'b01, 32'h0, 5'd6, 1'b1);
      @(negedge clk);
      check_out("mux_mem", 1'b1, 32'hDEAD_BEEF, 5'd6, 1'b1, 1'b1);
      offer(1'b1, 2'b10, 32'h0, 5'd7, 1'b1);
      @(negedge clk);
      check_out("mux_pc4", 1'b1, 32'h0000_0104, 5'd7, 1'b1, 1'b1);
      offer(1'b1, 2'b11, 32'h0, 5'd8, 1'b0);
      @(negedge clk);
      check_out("mux_imm", 1'b1, 32'hFFFF_F800, 5'd8, 1'b0, 1'b1);
      offer(1'b0, 2'b00, 32'h0, 5'd0, 1'b0);
      @(negedge clk);
      check_out("drain", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

      // Backpressure: A at head, B in skid, C refused
      io.w_ready = 1'b0;
      offer(1'b1, 2'b00, 32'h0000_AAAA, 5'd9, 1'b1);
      @(negedge clk);
      check_out("bp_a_full", 1'b1, 32'h0000_AAAA, 5'd9, 1'b1, 1'b1);
      offer(1'b1, 2'b00, 32'h0000_BBBB, 5'd10, 1'b1);
      @(negedge clk);
      check_out("bp_b_skid", 1'b1, 32'h0000_AAAA, 5'd9, 1'b1, 1'b0);
      offer(1'b1, 2'b00, 32'h0000_CCCC, 5'd11, 1'b1);
      @(negedge clk);
      check_out("bp_hold", 1'b1, 32'h0000_AAAA, 5'd9, 1'b1, 1'b0);
      offer(1'b0, 2'b00, 32'h0, 5'd0, 1'b0);
      io.w_ready = 1'b1;
      @(negedge clk);
      check_out("bp_b_head", 1'b1, 32'h0000_BBBB, 5'd10, 1'b1, 1'b1);
      @(negedge clk);
      check_out("bp_empty", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

      // x0 write suppression
      offer(1'b1, 2'b00, 32'h0000_0055, 5'd0, 1'b1);
      @(negedge clk);
      check_out("x0", 1'b1, 32'h0000_0055, 5'd0, 1'b0, 1'b1);
      offer(1'b0, 2'b00, 32'h0, 5'd0, 1'b0);
      @(negedge clk);
      check_out("x0_drain", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

      // Flush in SKID with simultaneous offer
      io.w_ready = 1'b0;
      offer(1'b1, 2'b00, 32'h0000_D00D, 5'd12, 1'b1);
      @(negedge clk);
      offer(1'b1, 2'b00, 32'h0000_E00E, 5'd13, 1'b1);
      @(negedge clk);
      check_out("fl_skid", 1'b1, 32'h0000_D00D, 5'd12, 1'b1, 1'b0);
      flush_w    = 1'b1;
      io.w_ready = 1'b1;
      offer(1'b1, 2'b00, 32'h0000_F00F, 5'd14, 1'b1);
      @(negedge clk);
      check_out("fl_skid_after", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
`ifdef MW_PIPE_PERF_EN
      check("fl_skid.perf_flush", perf_flush, 32'd1);
`endif
      flush_w = 1'b0;
      offer(1'b0, 2'b00, 32'h0, 5'd0, 1'b0);
      @(negedge clk);
      check_out("fl_skid_quiet", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

      // Flush in FULL discards a same-cycle accept
      io.w_ready = 1'b0;
      offer(1'b1, 2'b00, 32'h0000_1111, 5'd15, 1'b1);
      @(negedge clk);
      check_out("fl_full", 1'b1, 32'h0000_1111, 5'd15, 1'b1, 1'b1);
      flush_w = 1'b1;
      offer(1'b1, 2'b00, 32'h0000_2222, 5'd16, 1'b1);
      @(negedge clk);
      check_out("fl_full_after", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
      flush_w = 1'b0;
      offer(1'b0, 2'b00, 32'h0, 5'd0, 1'b0);
      @(negedge clk);
      check_out("fl_full_quiet", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
`ifdef MW_PIPE_PERF_EN
      check("fl_full.perf_flush", perf_flush, 32'd2);
`endif

      // Reset mid-operation while in SKID
      offer(1'b1, 2'b00, 32'h0000_3333, 5'd17, 1'b1);
      @(negedge clk);
      offer(1'b1, 2'b00, 32'h0000_4444, 5'd18, 1'b1);
      @(negedge clk);
      check_out("rst_skid", 1'b1, 32'h0000_3333, 5'd17, 1'b1, 1'b0);
      rst_n      = 1'b0;
      io.w_ready = 1'b1;
      @(negedge clk);
      check_out("rst_mid", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
`ifdef MW_PIPE_PERF_EN
      check("rst_mid.perf_flush", perf_flush, 32'd0);
`endif
      rst_n = 1'b1;
      offer(1'b1, 2'b00, 32'h0000_1234, 5'd5, 1'b1);
      @(negedge clk);
      check_out("post_rst", 1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b1);
      offer(1'b0, 2'b00, 32'h0, 5'd0, 1'b0);
      @(negedge clk);
      check_out("post_rst_drain", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
